// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: bus widths, register addresses and state encoding shared by the sprite DMA.
package oam_dma_pkg;
   localparam int ADDR_W = 16;
   localparam int REG_W = 8;
   localparam logic [15:0] TRIG_ADDR = 16'h4014;
   localparam logic [15:0] OAM_ADDR = 16'h2004;
   typedef enum logic [2:0] {
      DMA_IDLE,
      DMA_HALT,
      DMA_ALIGN,
      DMA_READ,
      DMA_WRITE
   } dma_state_t;
endpackage

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA master; a $4014 write stalls the CPU and copies one page to the OAM data port.
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int REG_WIDTH = REG_W,
   parameter logic [ADDR_WIDTH-1:0] DMA_TRIG_ADDR = TRIG_ADDR,
   parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = OAM_ADDR
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [REG_WIDTH-1:0]  cpu_dout,
   input  logic                  cpu_r_w_n,
   input  logic [REG_WIDTH-1:0]  mem_din,
   output logic                  rdy,
   output logic                  dma_active,
   output logic [ADDR_WIDTH-1:0] dma_addr,
   output logic [REG_WIDTH-1:0]  dma_dout,
   output logic                  dma_r_w_n
);
   dma_state_t state, state_nxt;
   logic [REG_WIDTH-1:0] page, idx, data;
   logic parity;
   logic trig;
   assign trig = (cpu_addr == DMA_TRIG_ADDR) && !cpu_r_w_n;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= DMA_IDLE;
         page <= '0;
         idx <= '0;
         data <= '0;
         parity <= 1'b0;
      end else begin
         state <= state_nxt;
         parity <= ~parity;
         if (state == DMA_IDLE && trig) begin
            page <= cpu_dout;
            idx <= '0;
         end
         if (state == DMA_READ) data <= mem_din;
         if (state == DMA_WRITE) idx <= idx + 1'b1;
      end
   end
   // HALT waits out CPU write cycles; parity picks whether a dummy read is needed
   always_comb begin
      state_nxt = state;
      case (state)
         DMA_IDLE:  state_nxt = trig ? DMA_HALT : DMA_IDLE;
         DMA_HALT:  state_nxt = !cpu_r_w_n ? DMA_HALT : parity ? DMA_READ : DMA_ALIGN;
         DMA_ALIGN: state_nxt = DMA_READ;
         DMA_READ:  state_nxt = DMA_WRITE;
         DMA_WRITE: state_nxt = &idx ? DMA_IDLE : DMA_READ;
         default:   state_nxt = DMA_IDLE;
      endcase
   end
   assign rdy = state == DMA_IDLE;
   assign dma_active = state == DMA_ALIGN || state == DMA_READ || state == DMA_WRITE;
   assign dma_r_w_n = state != DMA_WRITE;
   assign dma_addr = state == DMA_WRITE ? OAM_DATA_ADDR
                   : dma_active ? ADDR_WIDTH'({page, idx}) : '0;
   assign dma_dout = data;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed checks of the sprite DMA cycle sequence, alignment, HALT extension and reset.
`timescale 1ns/1ps
module tb_oam_dma;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic [7:0] cpu_dout = 8'h00;
   logic cpu_r_w_n = 1'b1;
   logic [7:0] mem_din;
   logic [7:0] key = 8'h00;
   logic rdy, dma_active, dma_r_w_n;
   logic [15:0] dma_addr;
   logic [7:0] dma_dout;
   logic [26:0] bus;
   logic [7:0] last_data = 8'h00;
   int errors = 0;
   int checks = 0;
   int edges = 0;

   oam_dma dut (
      .clk(clk),
      .reset_n(reset_n),
      .cpu_addr(cpu_addr),
      .cpu_dout(cpu_dout),
      .cpu_r_w_n(cpu_r_w_n),
      .mem_din(mem_din),
      .rdy(rdy),
      .dma_active(dma_active),
      .dma_addr(dma_addr),
      .dma_dout(dma_dout),
      .dma_r_w_n(dma_r_w_n)
   );

   assign mem_din = dma_addr[7:0] ^ key;
   assign bus = {rdy, dma_active, dma_r_w_n, dma_addr, dma_dout};

   always #5 clk = ~clk;

   // edges since reset release mirrors the free-running parity (parity = edges % 2)
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) edges <= 0;
      else edges <= edges + 1;
   end

   task automatic run_xfer(input logic [7:0] pg, input logic [7:0] k, input int extra,
                           input bit want_align, input string name);
      logic [26:0] exp;
      int stall;
      stall = 0;
      key = k;
      if ((((edges + 1 + extra) % 2) == 0) != want_align) @(negedge clk);
      cpu_addr = 16'h4014;
      cpu_r_w_n = 1'b0;
      cpu_dout = pg;
      @(negedge clk);
      cpu_addr = 16'h0000;
      cpu_dout = 8'h00;
      for (int h = 0; h <= extra; h++) begin
         cpu_r_w_n = (h == extra);
         exp = {3'b001, 16'h0000, last_data};
         checks++;
         if (bus !== exp) begin
            errors++;
            $display("FAIL %s halt%0d: got %h want %h", name, h, bus, exp);
         end
         stall += int'(!rdy);
         @(negedge clk);
      end
      if (want_align) begin
         exp = {3'b011, pg, 8'h00, last_data};
         checks++;
         if (bus !== exp) begin
            errors++;
            $display("FAIL %s align: got %h want %h", name, bus, exp);
         end
         stall += int'(!rdy);
         @(negedge clk);
      end
      for (int i = 0; i < 256; i++) begin
         exp = {3'b011, pg, 8'(i), last_data};
         checks++;
         if (bus !== exp) begin
            errors++;
            $display("FAIL %s read%0d: got %h want %h", name, i, bus, exp);
         end
         stall += int'(!rdy);
         @(negedge clk);
         last_data = 8'(i) ^ k;
         exp = {3'b010, 16'h2004, last_data};
         checks++;
         if (bus !== exp) begin
            errors++;
            $display("FAIL %s write%0d: got %h want %h", name, i, bus, exp);
         end
         stall += int'(!rdy);
         @(negedge clk);
      end
      exp = {3'b101, 16'h0000, last_data};
      checks++;
      if (bus !== exp) begin
         errors++;
         $display("FAIL %s done: got %h want %h", name, bus, exp);
      end
      checks++;
      if (stall !== 513 + extra + int'(want_align)) begin
         errors++;
         $display("FAIL %s stall: got %0d want %0d", name, stall, 513 + extra + int'(want_align));
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (bus !== {3'b101, 16'h0000, 8'h00}) begin
         errors++;
         $display("FAIL reset_hold: got %h want %h", bus, {3'b101, 16'h0000, 8'h00});
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus !== {3'b101, 16'h0000, 8'h00}) begin
         errors++;
         $display("FAIL reset_release: got %h want %h", bus, {3'b101, 16'h0000, 8'h00});
      end
   endtask

   task automatic test_non_trigger();
      cpu_addr = 16'h4014;
      cpu_r_w_n = 1'b1;
      cpu_dout = 8'h55;
      @(negedge clk);
      checks++;
      if (bus !== {3'b101, 16'h0000, last_data}) begin
         errors++;
         $display("FAIL read_4014: got %h want %h", bus, {3'b101, 16'h0000, last_data});
      end
      cpu_addr = 16'h4015;
      cpu_r_w_n = 1'b0;
      @(negedge clk);
      cpu_addr = 16'h0000;
      cpu_r_w_n = 1'b1;
      checks++;
      if (bus !== {3'b101, 16'h0000, last_data}) begin
         errors++;
         $display("FAIL write_4015: got %h want %h", bus, {3'b101, 16'h0000, last_data});
      end
      @(negedge clk);
      checks++;
      if (bus !== {3'b101, 16'h0000, last_data}) begin
         errors++;
         $display("FAIL non_trig_idle: got %h want %h", bus, {3'b101, 16'h0000, last_data});
      end
   endtask

   task automatic test_even();
      run_xfer(8'h02, 8'h5A, 0, 1'b0, "even");
   endtask

   task automatic test_odd();
      run_xfer(8'h02, 8'hA5, 0, 1'b1, "odd");
   endtask

   task automatic test_halt_ext();
      run_xfer(8'h07, 8'h3C, 2, 1'b0, "halt_ext_even");
      run_xfer(8'h07, 8'hC3, 2, 1'b1, "halt_ext_odd");
   endtask

   task automatic test_page_wrap();
      run_xfer(8'hFF, 8'h00, 0, 1'b0, "page_wrap");
   endtask

   task automatic test_back_to_back();
      run_xfer(8'h10, 8'h81, 0, 1'b1, "b2b_a");
      run_xfer(8'h11, 8'h18, 0, 1'b0, "b2b_b");
   endtask

   task automatic test_reset_mid();
      int n;
      key = 8'h00;
      cpu_addr = 16'h4014;
      cpu_r_w_n = 1'b0;
      cpu_dout = 8'h03;
      @(negedge clk);
      cpu_addr = 16'h0000;
      cpu_r_w_n = 1'b1;
      n = 0;
      while (n < 600 && dma_addr !== 16'h0364) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (dma_addr !== 16'h0364) begin
         errors++;
         $display("FAIL reset_mid_reach: got %h want %h", dma_addr, 16'h0364);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (bus !== {3'b101, 16'h0000, 8'h00}) begin
         errors++;
         $display("FAIL reset_mid: got %h want %h", bus, {3'b101, 16'h0000, 8'h00});
      end
      last_data = 8'h00;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_xfer(8'h03, 8'h66, 0, 1'b0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_non_trigger();
      test_even();
      test_odd();
      test_halt_ext();
      test_page_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
